// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory pipe: access size encoding, FSM states,
// captured request control fields and the alignment helper.
package dmem_pkg;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

   typedef struct packed {
      logic       write;
      logic       sign;
      logic [1:0] size;
      logic       err;
   } req_ctl_t;

   // True when a half/word access does not sit on its natural boundary.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == SIZE_HALF) && addr_lo[0]) ||
             ((size == SIZE_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Combinational load formatter: picks byte/half/word out of a little-endian
// 32-bit window and applies sign or zero extension.
module dmem_load_ext
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] data_c
);

   always_comb begin
      data_c = word;
      case (size)
         SIZE_HALF: data_c = {{16{sign & word[15]}}, word[15:0]};
         SIZE_BYTE: data_c = {{24{sign & word[7]}}, word[7:0]};
         default:   data_c = word;
      endcase
   end

endmodule

// File: rtl/data_mem_pipe.sv
// Byte-addressed data memory with a fixed-latency request/response handshake.
// Optional DMEM_MISALIGN_TRAP_EN rejects misaligned half/word accesses.
module data_mem_pipe
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 17,
   parameter int unsigned LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic                  req_sign,
   input  logic [1:0]            req_size,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_W = 3;

   logic [7:0] mem [DEPTH];

   state_e                state, state_n;
   logic [CNT_W-1:0]      cnt, cnt_n;
   req_ctl_t              ctl;
   logic [ADDR_WIDTH-1:0] addr_q;

   logic                  accept_c;
   logic                  req_err_c;
   logic                  do_store_c;
   logic                  rsp_valid_n;
   logic [31:0]           rsp_rdata_n;
   logic                  rsp_err_n;
   logic [31:0]           rd_word_c;
   logic [31:0]           ld_data_c;

   assign accept_c = req_valid && req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
   assign req_err_c = (req_size == SIZE_ILL) || misaligned(req_size, req_addr[1:0]);
`else
   assign req_err_c = (req_size == SIZE_ILL);
`endif

   assign do_store_c = accept_c && !rst && req_write && !req_err_c;

   // Stores commit on the acceptance edge; offsets wrap through the address width.
   always_ff @(posedge clk) begin
      if (do_store_c) begin
         mem[req_addr] <= req_wdata[7:0];
         if (req_size != SIZE_BYTE) begin
            mem[req_addr + ADDR_WIDTH'(1)] <= req_wdata[15:8];
         end
         if (req_size == SIZE_WORD) begin
            mem[req_addr + ADDR_WIDTH'(2)] <= req_wdata[23:16];
            mem[req_addr + ADDR_WIDTH'(3)] <= req_wdata[31:24];
         end
      end
   end

   assign rd_word_c = {mem[addr_q + ADDR_WIDTH'(3)], mem[addr_q + ADDR_WIDTH'(2)],
                       mem[addr_q + ADDR_WIDTH'(1)], mem[addr_q]};

   dmem_load_ext u_load_ext (
      .word   (rd_word_c),
      .size   (ctl.size),
      .sign   (ctl.sign),
      .data_c (ld_data_c)
   );

   // Next-state and response formation.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      rsp_valid_n = 1'b0;
      rsp_rdata_n = rsp_rdata;
      rsp_err_n   = rsp_err;
      case (state)
         IDLE: begin
            if (accept_c) begin
               if (LATENCY == 1) begin
                  state_n = RESP;
                  cnt_n   = '0;
               end else begin
                  state_n = WAIT;
                  cnt_n   = CNT_W'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt_n == '0) begin
               state_n = RESP;
            end
         end
         RESP: begin
            state_n     = IDLE;
            rsp_valid_n = 1'b1;
            rsp_err_n   = ctl.err;
            rsp_rdata_n = (ctl.write || ctl.err) ? 32'h0 : ld_data_c;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ctl       <= '0;
         addr_q    <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         req_ready <= (state_n == IDLE);
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rsp_rdata_n;
         rsp_err   <= rsp_err_n;
         if (accept_c) begin
            ctl    <= '{write: req_write, sign: req_sign, size: req_size, err: req_err_c};
            addr_q <= req_addr;
         end
      end
   end

endmodule
